uart_rx_byte_fifo: RTL and testbench
====================================

// Module: uart_rx_byte_fifo
// PURPOSE
//  Byte buffer directly downstream of the UART receiver. Accepts bytes over the receiver's
//  data/data_valid/ready handshake, stores up to DEPTH bytes, and presents them first-word-fall-through
//  (FWFT) on a valid/ready port. Frees the receiver at once so it returns to idle for the next start bit.
//  Overflow drops the byte and sets a sticky flag.
// PARAMETERS
//  ADDR_W   4   log2 of storage depth; DEPTH = 2**ADDR_W bytes (ADDR_W >= 1)
// PORTS
//  clock_12MHz     in   1        system clock; sole clock domain
//  reset           in   1        synchronous, active-high reset
//  in_data         in   8        byte from receiver (data)
//  in_valid        in   1        receiver data_valid
//  in_ready        out  1        to receiver ready; single-cycle accept pulse
//  out_data        out  8        head-of-queue byte; valid only while out_valid=1
//  out_valid       out  1        queue non-empty
//  out_ready       in   1        consumer takes head byte when out_valid & out_ready
//  count           out  ADDR_W+1 bytes currently stored, 0..DEPTH
//  overflow        out  1        sticky; set when a byte is dropped
//  overflow_clear  in   1        clears overflow
// BEHAVIOUR
//  Reset: in_ready=0, out_valid=0, out_data=8'h00, count=0, overflow=0, pointers=0, holdoff=0.
//   Reset mid-transfer discards all stored bytes. Reset wins over every other input in that cycle.
//  Accept (push): in_valid=1 & holdoff=0 -> in_ready=1 for exactly one cycle (registered, so the
//   pulse appears the cycle after in_valid is seen). in_data is sampled in the pulse cycle.
//  Holdoff: the receiver keeps data_valid high for 1 cycle after seeing ready. So the cycle after
//   the in_ready pulse is a holdoff cycle: in_valid is ignored, in_ready=0.
//   Minimum spacing between accepted bytes is 3 cycles.
//  Push when count<DEPTH: write mem[wr_ptr], wr_ptr+1 mod DEPTH.
//  Push when count==DEPTH and no pop in the same cycle: byte is discarded, in_ready still pulses
//   (the receiver is never stalled), and overflow is set to 1.
//  Push with pop in the same cycle while full: the byte is stored (the pop frees a slot). No overflow.
//  Pop: out_valid & out_ready -> rd_ptr+1 mod DEPTH. out_ready is ignored while out_valid=0.
//  FWFT: out_data = mem[rd_ptr] and stays stable while out_valid=1 & out_ready=0.
//   A byte pushed into an empty queue at cycle N gives out_valid=1 with that byte at cycle N+1.
//  count: +1 on push only, -1 on pop only, unchanged on push+pop or no activity. Never exceeds DEPTH.
//   Never wraps below 0.
//  Pointers: ADDR_W bits, wrap DEPTH-1 -> 0. full/empty are derived from count.
//  overflow: set has priority over clear when both happen in the same cycle.
//  Push and pop both happening when count==0: the pop is not possible (out_valid=0). Only the push
//   occurs.
// CONFIGURATION
//  UART_RX_FIFO_STATS_EN defined: adds ports
//   rx_total  out 16  bytes accepted (stored)
//   rx_drops  out 16  bytes discarded on overflow
//   Both reset to 0, wrap at 16'hFFFF -> 0, and are unaffected by overflow_clear.
//  Undefined: these ports and their counters do not exist. Core behaviour is identical either way.
// TESTING
//  1 Reset, push 8'hA5 from a receiver model -> one in_ready pulse, out_valid=1 / out_data=A5
//    next cycle, count=1.
//  2 Receiver model holds data_valid 1 cycle past ready -> exactly one byte stored, count=1,
//    no duplicate byte.
//  3 Push 0x00..0x0F with out_ready=0 (DEPTH=16) -> count=16. Drain -> 00..0F in order,
//    count=0, out_valid=0.
//  4 Full queue, push 8'h77 with out_ready=0 -> in_ready pulses, byte dropped, overflow=1,
//    count=16. With STATS_EN: rx_drops=1.
//  5 Full queue, push 8'h55 in the same cycle as a pop -> count stays 16, overflow=0,
//    8'h55 is the last byte read out.
//  6 Assert reset with 5 bytes queued and a push in progress -> next cycle count=0,
//    out_valid=0, in_ready=0, overflow=0.

Source files
------------

// File: rtl/uart_rx_byte_fifo.sv
// ============================================================================
// uart_rx_byte_fifo
// ----------------------------------------------------------------------------
// Byte buffer sitting directly behind the UART receiver. Bytes arrive over the
// receiver's data/data_valid/ready handshake, are stored in a circular buffer
// of DEPTH = 2**ADDR_W entries and are presented first-word-fall-through on a
// valid/ready port. The receiver is never stalled: a byte that arrives while
// the buffer is full is dropped and the sticky overflow flag is raised.
//
// Parameters
//   ADDR_W          log2 of storage depth (>= 1)
//
// Ports
//   clock_12MHz     in   1         system clock, sole clock domain
//   reset           in   1         synchronous, active-high reset
//   in_data         in   8         byte from receiver
//   in_valid        in   1         receiver data_valid
//   in_ready        out  1         single-cycle accept pulse to receiver
//   out_data        out  8         head-of-queue byte (valid while out_valid)
//   out_valid       out  1         queue non-empty
//   out_ready       in   1         consumer takes head byte on valid & ready
//   count           out  ADDR_W+1  bytes currently stored, 0..DEPTH
//   overflow        out  1         sticky, set when a byte is dropped
//   overflow_clear  in   1         clears overflow (a same-cycle drop wins)
//
// Optional feature (macro UART_RX_FIFO_STATS_EN)
//   rx_total        out  16        bytes stored since reset (wrapping)
//   rx_drops        out  16        bytes dropped since reset (wrapping)
// ============================================================================
module uart_rx_byte_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clock_12MHz,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              overflow_clear
`ifdef UART_RX_FIFO_STATS_EN
    ,
    output logic [15:0]       rx_total,
    output logic [15:0]       rx_drops
`else
    // statistics ports are absent in this build
`endif
);

    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    // Receiver handshake: IDLE sees data_valid, ACK drives the one-cycle
    // ready pulse (and is the cycle in which the byte is taken), HOLD skips
    // the cycle in which the receiver still holds data_valid high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } hs_state_t;

    hs_state_t          state_q, state_d;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         out_data_q;

    logic               push;
    logic               pop;
    logic               full;
    logic               store;
    logic               drop;
    logic               bypass;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        unique case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_ACK;
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        push  = (state_q == ST_ACK);
        pop   = (count_q != '0) && out_ready;
        full  = (count_q == DEPTH_C);
        // A pop in the same cycle frees the slot a full queue would lack.
        store = push && (!full || pop);
        drop  = push && full && !pop;

        if (store) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        case ({store, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            overflow_d = 1'b1;
        else if (overflow_clear)
            overflow_d = 1'b0;

        // The next head slot is being written this very cycle: the array
        // read would return the old contents, so forward the incoming byte.
        bypass = store && (wr_ptr_q == rd_ptr_d);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock_12MHz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage array: write port plus a registered read of the *next* head
    // address, which keeps the output first-word-fall-through.
    // ------------------------------------------------------------------
    always_ff @(posedge clock_12MHz) begin
        if (store && !reset)
            mem[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clock_12MHz) begin
        if (reset)
            out_data_q <= 8'h00;
        else if (bypass)
            out_data_q <= in_data;
        else
            out_data_q <= mem[rd_ptr_d];
    end

`ifdef UART_RX_FIFO_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters, independent of overflow_clear
    // ------------------------------------------------------------------
    logic [15:0] rx_total_q, rx_total_d;
    logic [15:0] rx_drops_q, rx_drops_d;

    always_comb begin
        rx_total_d = rx_total_q;
        rx_drops_d = rx_drops_q;
        if (store) rx_total_d = rx_total_q + 16'd1;
        if (drop)  rx_drops_d = rx_drops_q + 16'd1;
    end

    always_ff @(posedge clock_12MHz) begin
        if (reset) begin
            rx_total_q <= 16'd0;
            rx_drops_q <= 16'd0;
        end else begin
            rx_total_q <= rx_total_d;
            rx_drops_q <= rx_drops_d;
        end
    end

    assign rx_total = rx_total_q;
    assign rx_drops = rx_drops_q;
`else
    // no statistics counters in this build
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == ST_ACK);
    assign out_data  = out_data_q;
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// ============================================================================
// tb_uart_rx_byte_fifo
// ----------------------------------------------------------------------------
// Inputs are driven 1 time unit after the rising edge; the monitor samples
// everything on the falling edge, where inputs and registered outputs are
// stable for the coming rising edge. The monitor keeps a queue of expected
// bytes and an expected overflow flag, checks the DUT against them every
// cycle and then applies the effect of the coming edge to the model.
// ============================================================================
module tb_uart_rx_byte_fifo;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              overflow_clear = 1'b0;
`ifdef UART_RX_FIFO_STATS_EN
    logic [15:0]       rx_total;
    logic [15:0]       rx_drops;
`endif

    always #5 clk = ~clk;

    uart_rx_byte_fifo #(.ADDR_W(ADDR_W)) dut (
        .clock_12MHz    (clk),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
`ifdef UART_RX_FIFO_STATS_EN
        ,
        .rx_total       (rx_total),
        .rx_drops       (rx_drops)
`endif
    );

    int          checks   = 0;
    int          failures = 0;

    // Reference model
    logic [7:0]  exp_q[$];
    bit          exp_over  = 1'b0;
    int unsigned exp_total = 0;
    int unsigned exp_drops = 0;
    logic [7:0]  last_pop  = 8'h00;
    bit          prev_rst  = 1'b0;
    bit          rand_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        bit pop_now;
        bit full_now;
        bit drop_now;
        if (prev_rst) begin
            check("rst_in_ready",  in_ready,  0);
            check("rst_out_valid", out_valid, 0);
            check("rst_count",     count,     0);
            check("rst_overflow",  overflow,  0);
            check("rst_out_data",  out_data,  0);
        end
        if (reset) begin
            exp_q.delete();
            exp_over  = 1'b0;
            exp_total = 0;
            exp_drops = 0;
            prev_rst  = 1'b1;
        end else begin
            prev_rst = 1'b0;
            check("count",     count,     exp_q.size());
            check("out_valid", out_valid, int'(exp_q.size() != 0));
            check("overflow",  overflow,  exp_over);
            if (exp_q.size() != 0)
                check("out_data", out_data, exp_q[0]);
`ifdef UART_RX_FIFO_STATS_EN
            check("rx_total", rx_total, int'(exp_total % 65536));
            check("rx_drops", rx_drops, int'(exp_drops % 65536));
`endif
            full_now = (exp_q.size() == DEPTH);
            pop_now  = (exp_q.size() != 0) && out_ready;
            drop_now = in_ready && full_now && !pop_now;
            if (pop_now) begin
                last_pop = out_data;
                void'(exp_q.pop_front());
            end
            if (in_ready) begin
                if (drop_now) begin
                    exp_over = 1'b1;
                    exp_drops++;
                end else begin
                    exp_q.push_back(in_data);
                    exp_total++;
                end
            end
            if (overflow_clear && !drop_now)
                exp_over = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Receiver model: raise data_valid, wait for ready, hold one more cycle
    // ------------------------------------------------------------------
    task automatic send_byte(input logic [7:0] b, input bit pop_at_pulse);
        int waited = 0;
        bit found  = 1'b0;
        @(posedge clk); #1;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            waited++;
            if (in_ready) begin
                found = 1'b1;
                break;
            end
        end
        check("ack_latency", found ? waited : 99, 1);
        if (found) begin
            if (pop_at_pulse) out_ready = 1'b1;
            @(posedge clk); #1;
            if (pop_at_pulse) out_ready = 1'b0;
            check("holdoff_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit empty = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (count == 0) begin
                empty = 1'b1;
                break;
            end
        end
        out_ready = 1'b0;
        check("drain_done", empty, 1);
        check("drain_out_valid", out_valid, 0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // 1/2: single byte, receiver holds valid past ready
        send_byte(8'hA5, 1'b0);
        check("t1_count",     count,     1);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data",  out_data,  8'hA5);
        drain();

        // 3: fill to DEPTH
        for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 1'b0);
        check("t3_count_full", count, DEPTH);

        // 4: push into full queue without pop
        send_byte(8'h77, 1'b0);
        check("t4_count",    count,    DEPTH);
        check("t4_overflow", overflow, 1);
`ifdef UART_RX_FIFO_STATS_EN
        check("t4_rx_drops", rx_drops, 1);
`endif
        overflow_clear = 1'b1;
        @(posedge clk); #1;
        overflow_clear = 1'b0;
        check("t4_cleared", overflow, 0);

        // 5: push into full queue together with a pop
        send_byte(8'h55, 1'b1);
        check("t5_count",    count,    DEPTH);
        check("t5_overflow", overflow, 0);
        drain();
        check("t5_last_byte", last_pop, 8'h55);
        check("t5_count_empty", count, 0);

        // Random traffic with random consumer and random clears
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 60; k++)
                    send_byte(8'($urandom_range(0, 255)), 1'b0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready      = ($urandom_range(0, 3) == 0);
                    overflow_clear = ($urandom_range(0, 15) == 0);
                end
                out_ready      = 1'b0;
                overflow_clear = 1'b0;
            end
        join
        drain();

        // 6: reset with 5 bytes queued and a push in its ready cycle
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        check("t6_count_before", count, 5);
        @(posedge clk); #1;
        in_data  = 8'hC3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        check("t6_pulse", in_ready, 1);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_count",     count,     0);
        check("t6_out_valid", out_valid, 0);
        check("t6_in_ready",  in_ready,  0);
        check("t6_overflow",  overflow,  0);

        // Recovery after reset
        send_byte(8'h3C, 1'b0);
        check("post_rst_count", count,    1);
        check("post_rst_data",  out_data, 8'h3C);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "watchdog");
    end

endmodule
